// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - Serial line and received-byte bundle for uart_rx
// Purpose: groups the serial input line and the receiver's result outputs.
// Signals:
//   i_rx_data      serial line into the receiver, idles high
//   o_byte_out     last correctly framed byte
//   o_data_valid   one-cycle pulse, o_byte_out just updated
//   o_frame_error  one-cycle pulse, stop bit sampled low
//   o_rx_active    receiver is inside a frame (START/DATA/STOP)
// Modports: master drives the line and observes results; slave is the receiver.
interface uart_rx_if;
  logic       i_rx_data;
  logic [7:0] o_byte_out;
  logic       o_data_valid;
  logic       o_frame_error;
  logic       o_rx_active;

  modport master (
    output i_rx_data,
    input  o_byte_out,
    input  o_data_valid,
    input  o_frame_error,
    input  o_rx_active
  );

  modport slave (
    input  i_rx_data,
    output o_byte_out,
    output o_data_valid,
    output o_frame_error,
    output o_rx_active
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre-of-bit sampling
// Purpose: recovers bytes from an 8N1 serial stream at BAUD_MULT clocks per bit.
// Ports:
//   i_uart_clk  sole clock, rising edge
//   i_reset     synchronous active-high reset
//   rx_if       uart_rx_if.slave: i_rx_data in; o_byte_out, o_data_valid,
//               o_frame_error, o_rx_active out (all outputs registered)
module uart_rx #(
  parameter int BAUD_MULT = 1666
) (
  input  logic     i_uart_clk,
  input  logic     i_reset,
  uart_rx_if.slave rx_if
);
  localparam int HALF = BAUD_MULT / 2;
  localparam int CW   = $clog2(BAUD_MULT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_MULT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          active_q, active_d;
  logic          sync1_q, rx_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line half a bit in; a high level here was a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counting a full bit from mid-start lands every sample mid-bit.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid-stop lets a back-to-back start bit be caught.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must go high before a new start is accepted.
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
  end

  always_ff @(posedge i_uart_clk) begin
    if (i_reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sync1_q   <= rx_if.i_rx_data;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign rx_if.o_byte_out    = byte_q;
  assign rx_if.o_data_valid  = valid_q;
  assign rx_if.o_frame_error = ferr_q;
  assign rx_if.o_rx_active   = active_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Self-checking bench for uart_rx with an event-schedule reference model
module tb_uart_rx;
  localparam int B   = 4;
  localparam int H   = B / 2;
  localparam int LAT = 2 + H + 9 * B;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  uart_rx_if bus ();

  uart_rx #(.BAUD_MULT(B)) dut (
    .i_uart_clk(clk),
    .i_reset   (rst),
    .rx_if     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       is_err;
    logic [7:0] b;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         act_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    bus.i_rx_data = v;
    tick(B);
  endtask

  // Schedules the pulse this frame must produce, then drives it bit by bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int e0;
    e0 = cyc + 1;
    if (stop) begin
      exp_q.push_back('{e0 + LAT, 1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back('{e0 + LAT, 1'b1, last_good});
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic glitch();
    bus.i_rx_data = 1'b0;
    tick(1);
    bus.i_rx_data = 1'b1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (bus.o_rx_active === 1'b1) act_cnt++;
    if (bus.o_data_valid !== 1'b0 || bus.o_frame_error !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.o_data_valid, bus.o_frame_error}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_kind", {bus.o_data_valid, bus.o_frame_error}, e.is_err ? 2'b01 : 2'b10);
        check("byte_out", bus.o_byte_out, e.b);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int         r;
    bus.i_rx_data = 1'b1;
    rst = 1'b1;
    tick(5);
    check("rst_byte_out", bus.o_byte_out, 8'h00);
    check("rst_valid", bus.o_data_valid, 0);
    check("rst_ferr", bus.o_frame_error, 0);
    check("rst_active", bus.o_rx_active, 0);
    rst = 1'b0;
    act_cnt = 0;
    tick(100);
    check("idle_active", act_cnt, 0);

    act_cnt = 0;
    send_frame(8'h48, 1'b1);
    tick(8);
    check("frame_active_cycles", act_cnt, H + 9 * B);
    check("byte_hold", bus.o_byte_out, 8'h48);

    act_cnt = 0;
    glitch();
    tick(10);
    check("glitch_active", act_cnt, H);
    send_frame(8'h21, 1'b1);
    tick(4);

    send_frame(8'h48, 1'b1);
    send_frame(8'h55, 1'b0);
    tick(3);
    act_cnt = 0;
    tick(57);
    check("wait_idle_active", act_cnt, 0);
    check("byte_after_ferr", bus.o_byte_out, 8'h48);
    bus.i_rx_data = 1'b1;
    tick(6);
    send_frame(8'h0A, 1'b1);
    tick(4);

    for (int i = 0; i < 13; i++) send_frame(msg[i], 1'b1);
    tick(4);
    check("burst_byte", bus.o_byte_out, 8'h0A);

    // Abort 0xA5 during data bit 3 with a one-cycle reset.
    rb = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rb[i]);
    bus.i_rx_data = rb[3];
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.i_rx_data = 1'b1;
    last_good = 8'h00;
    check("midrst_active", bus.o_rx_active, 0);
    check("midrst_byte_out", bus.o_byte_out, 8'h00);
    tick(10);
    send_frame(8'h3C, 1'b1);
    tick(4);

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      if (r == 0) begin
        glitch();
        tick($urandom_range(4, 8));
      end else if (r == 1) begin
        send_frame(rb, 1'b0);
        tick($urandom_range(1, 20));
        bus.i_rx_data = 1'b1;
        tick($urandom_range(3, 8));
      end else begin
        send_frame(rb, 1'b1);
        tick($urandom_range(0, 3));
      end
    end

    tick(50);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the downstream counterpart of `uart_tx`. It consumes the 8N1 bit stream that `uart_tx` produces on `o_tx_data`, or that arrives on a board pin, and returns bytes to the fabric. The receiver samples each bit at its centre using the same `BAUD_MULT` clocks-per-bit convention as `uart_tx`, so a `uart_tx`/`uart_rx` pair with equal `BAUD_MULT` forms a loopback. It reports every completed frame as a byte plus a one-cycle valid pulse, or as a one-cycle framing-error pulse.

## Interface
- `BAUD_MULT`, default 1666: clock cycles per bit. Must be ≥ 4.
- `HALF` (localparam) = `BAUD_MULT/2`, integer division.
- Counter width is `$clog2(BAUD_MULT)`.

Ports:
- `i_uart_clk`  in  1  sole clock; all logic is on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  1  asynchronous serial input; idles high.
- `o_byte_out`  out  8  last correctly framed byte; holds until the next good frame.
- `o_data_valid`  out  1  one-cycle pulse: `o_byte_out` was just updated.
- `o_frame_error`  out  1  one-cycle pulse: stop bit was sampled low.
- `o_rx_active`  out  1  high in START, DATA and STOP.

## Operation
- **Synchronizer:** `i_rx_data` passes through 2 flops, giving `rx_s`. Both flops reset to 1. The state machine uses only `rx_s`.
- **States:** IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE.
- **IDLE:**
  - If `rx_s==0`: go to START and set `cnt=0`.
- **START** (checks the middle of the start bit):
  - If `cnt==HALF-1` and `rx_s==0`: go to DATA with `cnt=0` and `bit_idx=0`.
  - If `cnt==HALF-1` and `rx_s==1`: treat as a glitch, go to IDLE, assert no outputs.
  - Otherwise: `cnt++`.
- **DATA:**
  - If `cnt==BAUD_MULT-1`: `shift[bit_idx] <= rx_s` (LSB first), set `cnt=0`. If `bit_idx==7`, go to STOP; otherwise `bit_idx++`.
  - Otherwise: `cnt++`.
- **STOP:**
  - If `cnt==BAUD_MULT-1` and `rx_s==1`: set `o_byte_out<=shift`, pulse `o_data_valid`, go to IDLE.
  - If `cnt==BAUD_MULT-1` and `rx_s==0`: pulse `o_frame_error`, leave `o_byte_out` unchanged, go to WAIT_IDLE.
  - Otherwise: `cnt++`.
- **WAIT_IDLE** (break or line held low):
  - Stay until `rx_s==1`, then go to IDLE. A falling edge is never treated as a start bit while in this state.
- **Start-bit spacing:** the receiver returns to IDLE at mid-stop-bit. A start bit that follows the stop bit immediately, with no idle gap, is therefore caught. This covers back-to-back frames from `uart_tx`.
- **Reset values:** `o_byte_out=0`, `o_data_valid=0`, `o_frame_error=0`, `o_rx_active=0`, `cnt=0`, `bit_idx=0`, `shift=0`.
- **Reset has priority** over every state transition. Reset asserted mid-frame discards the partial byte and produces no pulse.
- `o_data_valid` and `o_frame_error` are mutually exclusive and never high for more than 1 cycle.

## Timing
- Let E0 be the first clock edge at which `i_rx_data` is sampled low.
- `rx_s` goes low after E1. IDLE→START occurs at E2.
- START→DATA occurs at E(2+HALF).
- Data bit n is sampled at E(2+HALF+(n+1)·BAUD_MULT), for n = 0..7.
- The stop bit is sampled at E(2+HALF+9·BAUD_MULT). The `o_data_valid` or `o_frame_error` pulse occupies the cycle after that edge.
- `o_rx_active` rises after E2 and falls after the stop-sample edge.
- Total latency from start edge to valid: `2+HALF+9·BAUD_MULT` cycles. For `BAUD_MULT=4` that is 40 cycles.
- Sampling tolerance is ±HALF cycles of cumulative drift per frame. No baud-rate tracking is done.

## Test plan
Every bench runs with `BAUD_MULT=4`, driving `i_rx_data` either from a bit-level model or from a `uart_tx` instance with `BAUD_MULT=4`.
1. **Reset:** hold `i_reset` for 5 cycles with the line high. Require all outputs 0 and `o_byte_out=8'h00`. Release and hold the line idle for 100 cycles; require no pulse.
2. **Single byte:** send 0x48 ('H'). Require `o_data_valid` high for exactly 1 cycle, 40 cycles after E0, with `o_byte_out=8'h48` and `o_frame_error=0`.
3. **Glitch:** drive the line low for 1 cycle, then high. Require `o_rx_active` high for exactly HALF=2 cycles, then a return to IDLE, with no valid or error pulse. A following frame 0x21 must be received correctly.
4. **Framing error:** receive 0x48, then send 0x55 with its stop bit low and the line held low for 60 cycles.
   - Require one `o_frame_error` pulse and `o_byte_out` still 8'h48.
   - Require no further activity while the line stays low.
   - Release the line high, then send 0x0A. Require `o_data_valid` with 8'h0A.
5. **Loopback burst:** `uart_tx` sends "Hello World!\n" back-to-back with no gap. Require 13 `o_data_valid` pulses in order: 0x48 65 6C 6C 6F 20 57 6F 72 6C 64 21 0A. Require zero frame errors.
6. **Reset mid-frame:** assert `i_reset` for 1 cycle during data bit 3 of 0xA5. Require no pulse, state IDLE after 1 cycle, and `o_byte_out=8'h00`. A subsequent frame 0x3C must be received correctly.
